// File: rtl/calc_pkg.sv
// Shared constants, state type and small helpers for the 4x4 keypad scanner.
package calc_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } scan_state_e;

  // Position of the set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] onehot_index(input logic [KEY_ROWS-1:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < KEY_ROWS; i++) begin
      if (onehot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [KEY_COLS-1:0] col_drive(input logic [1:0] col);
    return ~(KEY_COLS'(1) << col);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-clk pulse on a 0->1 transition of a signal synchronous to clk.
// The history flop resets high so a level already high at reset release is not an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_pulse
);

  logic r_prev;

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_in;
  end

  assign o_pulse = i_in & ~r_prev;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive on each 1 kHz tick,
// debounces a single pressed key, reports it once, and waits for a debounced release.
module keypad_scan
  import calc_pkg::*;
#(
  parameter int DEB_TICKS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_1k,
  input  logic [KEY_ROWS-1:0]   row_in,
  output logic [KEY_COLS-1:0]   col_out,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_held
);

  localparam int               CNT_W   = $clog2(DEB_TICKS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_TICKS);

  logic [KEY_ROWS-1:0]   r_row_meta;
  logic [KEY_ROWS-1:0]   r_row_sync;
  logic                  w_tick;

  scan_state_e           r_state;
  scan_state_e           w_state_nxt;
  logic [1:0]            r_col;
  logic [1:0]            w_col_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [1:0]            r_cand_row;
  logic [1:0]            w_cand_row_nxt;
  logic [KEY_CODE_W-1:0] r_key_code;
  logic [KEY_CODE_W-1:0] w_key_code_nxt;
  logic                  r_key_held;
  logic                  w_key_held_nxt;
  logic                  r_key_valid;
  logic                  w_key_valid_nxt;
  logic [KEY_COLS-1:0]   r_col_out;

  logic [KEY_ROWS-1:0]   w_rows_low;
  logic                  w_none_low;
  logic                  w_one_low;
  logic [1:0]            w_low_idx;
  logic                  w_same_key;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [1:0]            w_col_inc;

  // Rows are asynchronous keypad contacts; idle (pulled-up) is all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
    end
  end

  rise_detect u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_in    (clk_1k),
    .o_pulse (w_tick)
  );

  assign w_rows_low = ~r_row_sync;
  assign w_none_low = (w_rows_low == '0);
  assign w_one_low  = ($countones(w_rows_low) == 1);
  assign w_low_idx  = onehot_index(w_rows_low);
  assign w_same_key = w_one_low && (w_low_idx == r_cand_row);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_col_inc  = r_col + 2'd1;

  always_comb begin
    // NOTE: every next value gets its hold default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_cnt_nxt       = r_cnt;
    w_cand_row_nxt  = r_cand_row;
    w_key_code_nxt  = r_key_code;
    w_key_held_nxt  = r_key_held;
    w_key_valid_nxt = 1'b0;

    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (w_one_low) begin
            w_cand_row_nxt = w_low_idx;
            w_cnt_nxt      = CNT_W'(1);
            w_state_nxt    = DEBOUNCE;
          end else begin
            w_col_nxt = w_col_inc;
          end
        end

        DEBOUNCE: begin
          if (!w_same_key) begin
            w_cnt_nxt   = '0;
            w_state_nxt = SCAN;
            w_col_nxt   = w_col_inc;
          end else if (r_cnt == DEB_MAX) begin
            // Code is row*4 + col, which is simply the two indices concatenated.
            w_key_code_nxt  = {r_cand_row, r_col};
            w_key_valid_nxt = 1'b1;
            w_key_held_nxt  = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = HOLD;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end

        HOLD: begin
          if (!w_none_low) begin
            w_cnt_nxt = '0;
          end else if (w_cnt_inc == DEB_MAX) begin
            w_key_held_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_state_nxt    = SCAN;
            w_col_nxt      = w_col_inc;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end

        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col       <= 2'd0;
      r_cnt       <= '0;
      r_cand_row  <= 2'd0;
      r_key_code  <= '0;
      r_key_held  <= 1'b0;
      r_key_valid <= 1'b0;
      r_col_out   <= col_drive(2'd0);
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand_row  <= w_cand_row_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_held  <= w_key_held_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_col_out   <= col_drive(w_col_nxt);
    end
  end

  assign col_out   = r_col_out;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;

  a_one_col_driven: assert property (@(posedge clk) disable iff (rst) $onehot(~col_out));
  a_valid_implies_held: assert property (@(posedge clk) disable iff (rst) key_valid |-> key_held);

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised and directed bench for keypad_scan with a per-tick keypad reference model
// and a key_valid scoreboard drained by an independent monitor.
module tb_keypad_scan;

  localparam int DEB = 20;
  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1k;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [15:0] keys;   // bit row*4+col set while that key is physically pressed

  typedef struct {
    logic [3:0] code;
    int         tick;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   tick_num = 0;
  int   n_seen = 0;
  int   n_exp = 0;

  int m_phase, m_col, m_cand, m_streak, m_clean, m_code, m_held;

  always #5 clk = ~clk;

  keypad_scan #(.DEB_TICKS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_1k    (clk_1k),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // Physical matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at tick %0d",
               name, act, act, exp, exp, tick_num);
    end
  endtask

  task automatic model_reset();
    m_phase = M_SCAN; m_col = 0; m_cand = 0;
    m_streak = 0; m_clean = 0; m_code = 0; m_held = 0;
  endtask

  // One scan tick of the keypad behaviour, seen from the column driven during that tick.
  task automatic model_tick();
    int   low[$];
    exp_t e;
    tick_num++;
    for (int r = 0; r < 4; r++)
      if (keys[r*4+m_col]) low.push_back(r);
    case (m_phase)
      M_SCAN: begin
        if (low.size() == 1) begin
          m_cand = low[0]; m_streak = 0; m_phase = M_CONFIRM;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end
      M_CONFIRM: begin
        if (low.size() == 1 && low[0] == m_cand) begin
          m_streak++;
          if (m_streak == DEB) begin
            m_code = m_cand * 4 + m_col;
            m_held = 1; m_clean = 0; m_phase = M_HELD;
            e.code = 4'(m_code);
            e.tick = tick_num;
            sb_q.push_back(e);
            n_exp++;
          end
        end else begin
          m_phase = M_SCAN; m_col = (m_col + 1) % 4;
        end
      end
      default: begin
        if (low.size() == 0) begin
          m_clean++;
          if (m_clean == DEB) begin
            m_held = 0; m_phase = M_SCAN; m_col = (m_col + 1) % 4;
          end
        end else begin
          m_clean = 0;
        end
      end
    endcase
  endtask

  task automatic check_state();
    logic [3:0] exp_col;
    exp_col = 4'hF;
    exp_col[m_col] = 1'b0;
    check("col_out", col_out, exp_col);
    check("key_held", key_held, m_held);
    check("key_code", key_code, m_code);
  endtask

  // One 8-clk period of clk_1k; the rising edge is placed 4 clks after any key change.
  task automatic do_tick();
    repeat (4) @(negedge clk);
    clk_1k = 1'b1;
    model_tick();
    @(negedge clk);
    check_state();
    repeat (3) @(negedge clk);
    clk_1k = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'd0);
    check("rst_key_held", key_held, 1'b0);
  endtask

  // Monitor: every key_valid pulse must match the oldest expected press.
  initial begin
    exp_t e;
    logic kv_prev;
    kv_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) begin
        n_seen++;
        check("key_valid_width", kv_prev, 1'b0);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key_valid: got pulse code=%0d, expected none at tick %0d",
                   key_code, tick_num);
        end else begin
          e = sb_q.pop_front();
          check("sb_key_code", key_code, e.code);
          check("sb_latency_tick", tick_num, e.tick);
          check("sb_held_on_valid", key_held, 1'b1);
        end
      end
      kv_prev = key_valid;
    end
  end

  initial begin
    int n0;
    int dur;
    int reached;
    rst = 1'b1;
    clk_1k = 1'b1;
    keys = '0;
    model_reset();

    // Reset with clk_1k already high: no tick may occur until it falls and rises again.
    do_reset();
    repeat (10) @(negedge clk);
    check("no_tick_before_rise", col_out, 4'b1110);
    clk_1k = 1'b0;

    // Clean press of row 2 / col 1.
    n0 = n_seen;
    keys[9] = 1'b1;
    repeat (40) do_tick();
    check("clean_pulses", n_seen - n0, 1);
    check("clean_code", key_code, 4'd9);
    check("clean_held", key_held, 1'b1);
    keys = '0;
    repeat (25) do_tick();
    check("clean_released", key_held, 1'b0);

    // Bouncing contact, then stable.
    n0 = n_seen;
    for (int t = 0; t < 15; t++) begin
      keys[9] = ((t / 3) % 2 == 0);
      do_tick();
    end
    check("bounce_no_early_pulse", n_seen - n0, 0);
    keys[9] = 1'b1;
    repeat (40) do_tick();
    check("bounce_pulses", n_seen - n0, 1);
    keys = '0;
    repeat (25) do_tick();

    // Two rows low in column 2: invalid, scanning keeps rotating.
    n0 = n_seen;
    keys[2] = 1'b1;
    keys[14] = 1'b1;
    repeat (12) do_tick();
    check("two_keys_pulses", n_seen - n0, 0);
    keys = '0;
    repeat (4) do_tick();

    // Release with a one-tick re-contact at release tick 10.
    n0 = n_seen;
    keys[9] = 1'b1;
    repeat (30) do_tick();
    keys = '0;
    repeat (9) do_tick();
    keys[9] = 1'b1;
    do_tick();
    keys = '0;
    repeat (19) do_tick();
    check("glitch_still_held", key_held, 1'b1);
    do_tick();
    check("glitch_released", key_held, 1'b0);
    check("glitch_pulses", n_seen - n0, 1);

    // Reset while debounce count is 12 with the key still pressed.
    keys[9] = 1'b1;
    reached = 0;
    for (int t = 0; t < 40 && reached == 0; t++) begin
      do_tick();
      if (m_phase == M_CONFIRM && m_streak + 1 == 12) reached = 1;
    end
    check("reached_count_12", reached, 1);
    do_reset();
    n0 = n_seen;
    repeat (30) do_tick();
    check("reset_redebounce_pulses", n_seen - n0, 1);
    keys = '0;
    repeat (25) do_tick();

    // Random presses, sometimes with a second key, random durations.
    for (int it = 0; it < 8; it++) begin
      keys = '0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      dur = $urandom_range(4, 45);
      repeat (dur) do_tick();
      keys = '0;
      dur = $urandom_range(22, 30);
      repeat (dur) do_tick();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("pulse_count", n_seen, n_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
